// File: rtl/vector_reg_file.sv
// Multi-lane SIMD register file: 2 async read ports with write bypass, 1 masked write
// port and a per-entry busy scoreboard. Define ZERO_REG_EN to hardwire entry 0 to zero.
`timescale 1ns/1ps

module vector_reg_file #(
  parameter  int N     = 24,
  parameter  int LANES = 4,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int W     = LANES * N
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [W-1:0]     rd1,
  output logic [W-1:0]     rd2,
  output logic             busy1,
  output logic             busy2,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [W-1:0]     wd,
  input  logic [LANES-1:0] wmask,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr
);

`ifdef ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  logic [W-1:0]     memR [DEPTH];
  logic [DEPTH-1:0] busyR;
  logic [DEPTH-1:0] nextBusyS;
  logic             writeEnS;
  logic             issueEnS;

  // Lane-wise select: masked lanes take the new value, the rest keep the old one.
  function automatic logic [W-1:0] mergeLanes(input logic [W-1:0] oldVal,
                                              input logic [W-1:0] newVal,
                                              input logic [LANES-1:0] mask);
    logic [W-1:0] res;
    res = oldVal;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        res[i*N +: N] = newVal[i*N +: N];
      end else begin
        res[i*N +: N] = oldVal[i*N +: N];
      end
    end
    return res;
  endfunction

  // Writes and issues aimed at a hardwired-zero entry are dropped here once.
  always_comb begin
    writeEnS = we     && !(ZeroReg && (wa       == {AW{1'b0}}));
    issueEnS = iss_en && !(ZeroReg && (iss_addr == {AW{1'b0}}));
  end

  // Scoreboard update: the clear is applied first so a same-entry issue wins.
  always_comb begin
    nextBusyS = busyR;
    if (writeEnS) begin
      nextBusyS[wa] = 1'b0;
    end else begin
      nextBusyS = nextBusyS;
    end
    if (issueEnS) begin
      nextBusyS[iss_addr] = 1'b1;
    end else begin
      nextBusyS = nextBusyS;
    end
  end

  // Storage and scoreboard state; reset discards any write in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        memR[i] <= {W{1'b0}};
      end
      busyR <= {DEPTH{1'b0}};
    end else begin
      if (writeEnS) begin
        memR[wa] <= mergeLanes(memR[wa], wd, wmask);
      end
      busyR <= nextBusyS;
    end
  end

  // Read port 1: zero while in reset or on the zero entry, else stored data with bypass.
  always_comb begin
    if (reset || (ZeroReg && (ra1 == {AW{1'b0}}))) begin
      rd1   = {W{1'b0}};
      busy1 = 1'b0;
    end else if (writeEnS && (wa == ra1)) begin
      rd1   = mergeLanes(memR[ra1], wd, wmask);
      busy1 = busyR[ra1] & (issueEnS && (iss_addr == ra1));
    end else begin
      rd1   = memR[ra1];
      busy1 = busyR[ra1];
    end
  end

  // Read port 2: identical to port 1.
  always_comb begin
    if (reset || (ZeroReg && (ra2 == {AW{1'b0}}))) begin
      rd2   = {W{1'b0}};
      busy2 = 1'b0;
    end else if (writeEnS && (wa == ra2)) begin
      rd2   = mergeLanes(memR[ra2], wd, wmask);
      busy2 = busyR[ra2] & (issueEnS && (iss_addr == ra2));
    end else begin
      rd2   = memR[ra2];
      busy2 = busyR[ra2];
    end
  end

endmodule
